// File: rtl/matrix_stream_compiler_if.sv
// Bundles the configuration, element-write, byte-stream and status signals of matrix_stream_compiler.
// The slave modport is the compiler's side of the bus; the master modport is the upstream/packetiser side.
interface matrix_stream_compiler_if #(
    parameter int ELEM_W   = 16,
    parameter int MAX_ROWS = 32,
    parameter int MAX_COLS = 32
);
    logic                            cfg_valid;
    logic [$clog2(MAX_ROWS+1)-1:0]   cfg_rows;
    logic [$clog2(MAX_COLS+1)-1:0]   cfg_cols;
    logic                            cfg_ready;
    logic                            in_valid;
    logic [$clog2(MAX_ROWS)-1:0]     in_row;
    logic [$clog2(MAX_COLS)-1:0]     in_col;
    logic [ELEM_W-1:0]               in_data;
    logic                            in_ready;
    logic                            data_request;
    logic                            out_valid;
    logic [7:0]                      out_byte;
    logic                            out_ready;
    logic                            out_last;
    logic                            compile_done;
    logic                            busy;
    logic                            err_dup;
    logic                            err_range;

    modport slave (
        input  cfg_valid, cfg_rows, cfg_cols, in_valid, in_row, in_col, in_data,
               data_request, out_ready,
        output cfg_ready, in_ready, out_valid, out_byte, out_last,
               compile_done, busy, err_dup, err_range
    );

    modport master (
        output cfg_valid, cfg_rows, cfg_cols, in_valid, in_row, in_col, in_data,
               data_request, out_ready,
        input  cfg_ready, in_ready, out_valid, out_byte, out_last,
               compile_done, busy, err_dup, err_range
    );
endinterface

// File: rtl/matrix_stream_compiler.sv
// Collects (row, col)-addressed elements in any order, then streams the matrix row-major as MSB-first bytes.
// Optional MATRIX_STREAM_HEADER_EN prepends a rows/cols header to each transmitted frame.
module matrix_stream_compiler #(
    parameter int ELEM_W   = 16,
    parameter int MAX_ROWS = 32,
    parameter int MAX_COLS = 32
) (
    input  logic inter_refclk,
    input  logic rst,
    matrix_stream_compiler_if.slave bus
);
    localparam int DEPTH = MAX_ROWS * MAX_COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(MAX_ROWS + 1);
    localparam int CW    = $clog2(MAX_COLS + 1);
    localparam int IRW   = $clog2(MAX_ROWS);
    localparam int ICW   = $clog2(MAX_COLS);
    localparam int TW    = $clog2(DEPTH + 1);
    localparam int BYTES = ELEM_W / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FULL, TX} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rows_q, rows_d;
    logic [CW-1:0]    cols_q, cols_d;
    logic [TW-1:0]    total_q, total_d;
    logic [TW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] tracker_q, tracker_d;
    logic             compile_done_q, compile_done_d;
    logic             err_dup_q, err_dup_d;
    logic             err_range_q, err_range_d;
    logic [IRW-1:0]   tx_row_q, tx_row_d;
    logic [ICW-1:0]   tx_col_q, tx_col_d;
    logic [BW-1:0]    byte_q, byte_d;
`ifdef MATRIX_STREAM_HEADER_EN
    logic [1:0]       hdr_q, hdr_d;
`endif

    logic [ELEM_W-1:0] mem [DEPTH];
    logic [ELEM_W-1:0] rd_data_q;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     wr_addr;
    logic              wr_en;
    logic              cfg_ok, in_range, payload, hs, byte_last, elem_last;
    logic [7:0]        elem_bytes [BYTES];

    assign cfg_ok    = (bus.cfg_rows != '0) && (bus.cfg_rows <= RW'(MAX_ROWS)) &&
                       (bus.cfg_cols != '0) && (bus.cfg_cols <= CW'(MAX_COLS));
    assign in_range  = (RW'(bus.in_row) < rows_q) && (CW'(bus.in_col) < cols_q);
    assign wr_addr   = AW'(bus.in_row) * AW'(MAX_COLS) + AW'(bus.in_col);
    assign hs        = (state_q == TX) && bus.out_ready;
    assign byte_last = (byte_q == BW'(BYTES - 1));
    assign elem_last = (RW'(tx_row_q) == rows_q - 1'b1) && (CW'(tx_col_q) == cols_q - 1'b1);
`ifdef MATRIX_STREAM_HEADER_EN
    assign payload   = (hdr_q == 2'd2);
`else
    assign payload   = 1'b1;
`endif

    // Reading the address of the *next* current element keeps rd_data_q aligned with tx_row_q/tx_col_q.
    assign rd_addr = AW'(tx_row_d) * AW'(MAX_COLS) + AW'(tx_col_d);

    always_comb begin
        state_d        = state_q;
        rows_d         = rows_q;
        cols_d         = cols_q;
        total_d        = total_q;
        count_d        = count_q;
        tracker_d      = tracker_q;
        compile_done_d = 1'b0;
        err_dup_d      = err_dup_q;
        err_range_d    = err_range_q;
        tx_row_d       = tx_row_q;
        tx_col_d       = tx_col_q;
        byte_d         = byte_q;
        wr_en          = 1'b0;
`ifdef MATRIX_STREAM_HEADER_EN
        hdr_d          = hdr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    if (cfg_ok) begin
                        rows_d      = bus.cfg_rows;
                        cols_d      = bus.cfg_cols;
                        total_d     = TW'(bus.cfg_rows) * TW'(bus.cfg_cols);
                        count_d     = '0;
                        err_dup_d   = 1'b0;
                        err_range_d = 1'b0;
                        state_d     = LOAD;
                    end else begin
                        err_range_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    if (!in_range) begin
                        err_range_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (tracker_q[wr_addr]) begin
                            err_dup_d = 1'b1;
                        end else begin
                            tracker_d[wr_addr] = 1'b1;
                            count_d            = count_q + 1'b1;
                            if (count_q + 1'b1 == total_q) begin
                                state_d        = FULL;
                                compile_done_d = 1'b1;
                            end
                        end
                    end
                end
            end
            FULL: begin
                if (bus.data_request) begin
                    state_d  = TX;
                    tx_row_d = '0;
                    tx_col_d = '0;
                    byte_d   = '0;
`ifdef MATRIX_STREAM_HEADER_EN
                    hdr_d    = 2'd0;
`endif
                end
            end
            TX: begin
                if (hs) begin
                    if (!payload) begin
`ifdef MATRIX_STREAM_HEADER_EN
                        hdr_d = hdr_q + 2'd1;
`endif
                    end else if (!byte_last) begin
                        byte_d = byte_q + 1'b1;
                    end else begin
                        byte_d = '0;
                        if (elem_last) begin
                            state_d   = IDLE;
                            tracker_d = '0;
                            count_d   = '0;
                            tx_row_d  = '0;
                            tx_col_d  = '0;
                        end else if (CW'(tx_col_q) == cols_q - 1'b1) begin
                            tx_col_d = '0;
                            tx_row_d = tx_row_q + 1'b1;
                        end else begin
                            tx_col_d = tx_col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            state_q        <= IDLE;
            rows_q         <= '0;
            cols_q         <= '0;
            total_q        <= '0;
            count_q        <= '0;
            tracker_q      <= '0;
            compile_done_q <= 1'b0;
            err_dup_q      <= 1'b0;
            err_range_q    <= 1'b0;
            tx_row_q       <= '0;
            tx_col_q       <= '0;
            byte_q         <= '0;
`ifdef MATRIX_STREAM_HEADER_EN
            hdr_q          <= 2'd0;
`endif
        end else begin
            state_q        <= state_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            total_q        <= total_d;
            count_q        <= count_d;
            tracker_q      <= tracker_d;
            compile_done_q <= compile_done_d;
            err_dup_q      <= err_dup_d;
            err_range_q    <= err_range_d;
            tx_row_q       <= tx_row_d;
            tx_col_q       <= tx_col_d;
            byte_q         <= byte_d;
`ifdef MATRIX_STREAM_HEADER_EN
            hdr_q          <= hdr_d;
`endif
        end
    end

    always_ff @(posedge inter_refclk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.in_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
            assign elem_bytes[gi] = rd_data_q[ELEM_W-1-8*gi -: 8];
        end
    endgenerate

    assign bus.cfg_ready    = (state_q == IDLE);
    assign bus.in_ready     = (state_q == LOAD);
    assign bus.out_valid    = (state_q == TX);
    assign bus.busy         = (state_q != IDLE);
    assign bus.compile_done = compile_done_q;
    assign bus.err_dup      = err_dup_q;
    assign bus.err_range    = err_range_q;
    assign bus.out_last     = (state_q == TX) && payload && byte_last && elem_last;
`ifdef MATRIX_STREAM_HEADER_EN
    assign bus.out_byte     = payload ? elem_bytes[byte_q] :
                              ((hdr_q == 2'd0) ? 8'(rows_q) : 8'(cols_q));
`else
    assign bus.out_byte     = elem_bytes[byte_q];
`endif
endmodule

// File: tb/tb_matrix_stream_compiler.sv
// Scoreboard bench for matrix_stream_compiler: stimulus pushes expected bytes, a monitor pops and compares.
module tb_matrix_stream_compiler;
    localparam int ELEM_W   = 16;
    localparam int MAX_ROWS = 32;
    localparam int MAX_COLS = 32;
    localparam int BYTES    = ELEM_W / 8;
    localparam int RW       = $clog2(MAX_ROWS + 1);
    localparam int CW       = $clog2(MAX_COLS + 1);
    localparam int IRW      = $clog2(MAX_ROWS);
    localparam int ICW      = $clog2(MAX_COLS);

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_stream_compiler_if #(.ELEM_W(ELEM_W), .MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS)) bus ();

    matrix_stream_compiler #(.ELEM_W(ELEM_W), .MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS)) dut (
        .inter_refclk (clk),
        .rst          (rst),
        .bus          (bus)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cd_count = 0;
    int   pops     = 0;
    int   cyc      = 0;
    int   first_hs = -1;
    int   last_hs  = -1;
    int   ready_mode = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on every handshake, plus stall-stability checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.compile_done) cd_count++;
                if (prev_stall) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_byte", bus.out_byte, prev_byte);
                    check("stall_last", bus.out_last, prev_last);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte actual=%0h required=none", bus.out_byte);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", bus.out_byte, e.b);
                        check("last", bus.out_last, e.l);
                    end
                    pops++;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_byte  = bus.out_byte;
                prev_last  = bus.out_last;
            end
        end
    end

    // out_ready generator: 0 = always ready, 1 = pattern 1,0,0 repeating.
    initial begin
        int phase = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                bus.out_ready = (phase == 0);
                phase = (phase + 1) % 3;
            end else begin
                bus.out_ready = 1'b1;
                phase = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic cfg(input int r, input int c);
        bus.cfg_valid = 1'b1;
        bus.cfg_rows  = RW'(r);
        bus.cfg_cols  = CW'(c);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wr(input int r, input int c, input logic [ELEM_W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_row   = IRW'(r);
        bus.in_col   = ICW'(c);
        bus.in_data  = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic push_elem(input logic [ELEM_W-1:0] v, input logic last);
        exp_t e;
        for (int b = 0; b < BYTES; b++) begin
            e.b = v[ELEM_W-1-8*b -: 8];
            e.l = last && (b == BYTES - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_header(input int r, input int c);
`ifdef MATRIX_STREAM_HEADER_EN
        exp_t e;
        e.l = 1'b0;
        e.b = 8'(r);
        exp_q.push_back(e);
        e.b = 8'(c);
        exp_q.push_back(e);
`else
        if (r < 0 || c < 0) $display("negative dims %0d %0d", r, c);
`endif
    endtask

    task automatic request();
        bit seen = 0;
        first_hs = -1;
        bus.data_request = 1'b1;
        @(posedge clk); #1;
        bus.data_request = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("first_valid_latency", seen, 1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && (bus.busy || exp_q.size() != 0); k++) @(negedge clk);
        check("done_busy", bus.busy, 0);
        check("drained", exp_q.size(), 0);
        check("done_out_valid", bus.out_valid, 0);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_compile_done", bus.compile_done, 0);
        check("rst_err_dup", bus.err_dup, 0);
        check("rst_err_range", bus.err_range, 0);
    endtask

    initial begin
        int cd_base;
        int pop_base;
        int n;
        bus.cfg_valid = 0; bus.cfg_rows = '0; bus.cfg_cols = '0;
        bus.in_valid = 0; bus.in_row = '0; bus.in_col = '0; bus.in_data = '0;
        bus.data_request = 0;
        repeat (3) @(posedge clk);
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;

        // 2x2 out of order, back-to-back stream
        cd_base = cd_count;
        cfg(2, 2);
        wr(1, 1, 16'hDDDD); wr(0, 0, 16'hAAAA); wr(1, 0, 16'hCCCC); wr(0, 1, 16'hBBBB);
        push_header(2, 2);
        push_elem(16'hAAAA, 0); push_elem(16'hBBBB, 0); push_elem(16'hCCCC, 0); push_elem(16'hDDDD, 1);
        n = exp_q.size();
        request();
        wait_done();
        check("no_bubble_span", last_hs - first_hs, n - 1);
        check("compile_done_pulses_2x2", cd_count - cd_base, 1);
        $display("T1 2x2 stream bytes=%0d", n);

        // Same matrix with out_ready stalls
        cd_base = cd_count;
        pop_base = pops;
        cfg(2, 2);
        wr(1, 1, 16'hDDDD); wr(0, 0, 16'hAAAA); wr(1, 0, 16'hCCCC); wr(0, 1, 16'hBBBB);
        push_header(2, 2);
        push_elem(16'hAAAA, 0); push_elem(16'hBBBB, 0); push_elem(16'hCCCC, 0); push_elem(16'hDDDD, 1);
        n = exp_q.size();
        ready_mode = 1;
        request();
        wait_done();
        ready_mode = 0;
        check("stall_byte_count", pops - pop_base, n);
        check("compile_done_pulses_stall", cd_count - cd_base, 1);
        $display("T2 2x2 stalled stream bytes=%0d", n);

        // 3x2 with duplicate and out-of-range writes
        cd_base = cd_count;
        cfg(3, 2);
        wr(2, 1, 16'h1111); wr(2, 1, 16'h2222); wr(3, 0, 16'h9999);
        wr(0, 0, 16'h0001); wr(0, 1, 16'h0002); wr(1, 0, 16'h0003); wr(1, 1, 16'h0004);
        @(negedge clk);
        check("dup_err_dup", bus.err_dup, 1);
        check("dup_err_range", bus.err_range, 1);
        check("dup_still_load", bus.in_ready, 1);
        check("dup_no_early_done", cd_count - cd_base, 0);
        @(posedge clk); #1;
        wr(2, 0, 16'h0005);
        push_header(3, 2);
        push_elem(16'h0001, 0); push_elem(16'h0002, 0); push_elem(16'h0003, 0);
        push_elem(16'h0004, 0); push_elem(16'h0005, 0); push_elem(16'h2222, 1);
        request();
        wait_done();
        check("compile_done_pulses_3x2", cd_count - cd_base, 1);
        check("flags_held_err_dup", bus.err_dup, 1);
        $display("T3 3x2 dup/range handled");

        // Bad configurations, then a valid 1x1 clears the flags
        cfg(0, 2);
        @(negedge clk);
        check("cfg0_err_range", bus.err_range, 1);
        check("cfg0_cfg_ready", bus.cfg_ready, 1);
        check("cfg0_busy", bus.busy, 0);
        @(posedge clk); #1;
        cfg(MAX_ROWS + 1, 2);
        @(negedge clk);
        check("cfg33_err_range", bus.err_range, 1);
        check("cfg33_busy", bus.busy, 0);
        @(posedge clk); #1;
        cfg(1, 1);
        @(negedge clk);
        check("cfg_ok_err_range", bus.err_range, 0);
        check("cfg_ok_err_dup", bus.err_dup, 0);
        check("cfg_ok_busy", bus.busy, 1);
        @(posedge clk); #1;
        wr(0, 0, 16'h1234);
        push_header(1, 1);
        push_elem(16'h1234, 1);
        request();
        wait_done();
        $display("T4 bad cfg rejected, 1x1 sent");

        // 2x3 matrix
        cfg(2, 3);
        push_header(2, 3);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) begin
                wr(r, c, ELEM_W'(16'hA000 + r * 16 + c));
                push_elem(ELEM_W'(16'hA000 + r * 16 + c), (r == 1) && (c == 2));
            end
        request();
        wait_done();
        $display("T5 2x3 stream done");

        // Full matrix, reset mid-TX
        cfg(MAX_ROWS, MAX_COLS);
        for (int r = 0; r < MAX_ROWS; r++)
            for (int c = 0; c < MAX_COLS; c++)
                wr(r, c, ELEM_W'(r * MAX_COLS + c));
        push_header(MAX_ROWS, MAX_COLS);
        for (int i = 0; i < 60; i++) push_elem(ELEM_W'(i), 0);
        pop_base = pops;
        request();
        for (int k = 0; k < 500 && pops < pop_base + 100; k++) @(posedge clk);
        check("reached_100_bytes", pops >= pop_base + 100, 1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tx_out_valid", bus.out_valid, 0);
        check("rst_mid_tx_busy", bus.busy, 0);
        exp_q.delete();
        check_reset_state();
        @(posedge clk); #1;
        rst = 1'b0;
        cd_base = cd_count;
        cfg(1, 1);
        wr(0, 0, 16'hBEEF);
        push_header(1, 1);
        push_elem(16'hBEEF, 1);
        pop_base = pops;
        request();
        wait_done();
        check("post_rst_bytes", pops - pop_base, exp_q.size() + BYTES
`ifdef MATRIX_STREAM_HEADER_EN
              + 2
`endif
              );
        check("post_rst_err_dup", bus.err_dup, 0);
        check("post_rst_compile_done", cd_count - cd_base, 1);
        $display("T6 reset mid-TX then 1x1 resend");

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_stream_compiler.md
Name: matrix_stream_compiler

Overview:
- Parametrised successor to the matrix collection block.
- Accepts matrix elements addressed by (row, col) in any order, with runtime-configurable dimensions, and tracks per-element arrival.
- When every element of the configured matrix has arrived, it streams the matrix row-major as bytes over a valid/ready interface to the Ethernet packetiser.
- Single clock domain; CDC is handled upstream.

Parameters:
ELEM_W, 16, element width in bits; multiple of 8, range 8..64
MAX_ROWS, 32, maximum runtime row count
MAX_COLS, 32, maximum runtime column count

Ports:
inter_refclk  input  1  clock
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  dimension configuration strobe
cfg_rows  input  $clog2(MAX_ROWS+1)  runtime row count
cfg_cols  input  $clog2(MAX_COLS+1)  runtime column count
cfg_ready  output  1  high in IDLE
in_valid  input  1  element write valid
in_row  input  $clog2(MAX_ROWS)  element row
in_col  input  $clog2(MAX_COLS)  element column
in_data  input  ELEM_W  element value
in_ready  output  1  high in LOAD
data_request  input  1  start-transmit request
out_valid  output  1  byte valid
out_byte  output  8  byte data
out_ready  input  1  downstream accept
out_last  output  1  final byte of matrix
compile_done  output  1  one-cycle pulse on matrix complete
busy  output  1  state != IDLE
err_dup  output  1  sticky flag: element written twice
err_range  output  1  sticky flag: bad configuration or out-of-range write

Behaviour:
- Reset: state IDLE; tracker and element count cleared; all outputs 0 except cfg_ready=1. Memory contents are don't-care.
- Storage: inferred array of MAX_ROWS*MAX_COLS x ELEM_W. Address = row*MAX_COLS+col. Synchronous read, 1-cycle latency. Tracker has 1 bit per entry.
- BYTES = ELEM_W/8. Bytes are emitted MSB first within each element.
- State IDLE:
  - cfg_valid with 1<=rows<=MAX_ROWS and 1<=cols<=MAX_COLS: latch dimensions, total=rows*cols, go to LOAD.
  - Any other cfg_valid value: set err_range, stay in IDLE.
  - in_valid is ignored.
- State LOAD:
  - A write is accepted when in_valid is high (in_ready=1).
  - in_row>=rows or in_col>=cols: write dropped, err_range set.
  - Tracker bit already set: data overwritten, err_dup set, count unchanged.
  - Otherwise: write data, set tracker bit, count+1.
  - When an accepted write brings count to total: compile_done pulses on the next cycle and state goes to FULL.
  - cfg_valid is ignored outside IDLE.
- State FULL:
  - in_ready=0.
  - data_request sampled high: go to TX, element index=0, byte index=0, issue read.
  - data_request during the compile_done cycle counts, because state is already FULL in that cycle.
- State TX:
  - First out_valid appears within 3 cycles of data_request being sampled.
  - out_byte and out_last stay stable while out_valid && !out_ready.
  - A byte advances only on out_valid && out_ready. No bubbles are allowed when out_ready is held high: one byte per cycle, with read prefetch.
  - Element order: row-major over the runtime dims, r=0..rows-1, c=0..cols-1.
  - out_last is high only on byte BYTES-1 of element total-1.
  - After the last handshake: out_valid=0, tracker and count cleared, err flags held, state goes to IDLE.
- Sticky flags clear only on rst or on an accepted cfg_valid.
- rst mid-LOAD or mid-TX: state returns to IDLE within one cycle, out_valid drops immediately, and no partial frame resumes.
- Widths: total is computed at $clog2(MAX_ROWS*MAX_COLS+1) bits. The element index wraps only at total.

Optional Feature:
- Macro: MATRIX_STREAM_HEADER_EN.
- Defined:
  - TX first emits a 2-byte header, byte0=rows and byte1=cols, zero-extended or truncated to 8 bits, then the payload.
  - out_last is unchanged and stays on the final payload byte.
  - Header bytes follow the same valid/ready rules.
- Undefined: the payload starts immediately and no header logic is synthesised.

Test Plan:
- Config 2x2, ELEM_W=16; write (1,1)=0xDDDD, (0,0)=0xAAAA, (1,0)=0xCCCC, (0,1)=0xBBBB; then data_request with out_ready=1 -> compile_done pulses once, then bytes AA AA BB BB CC CC DD DD on consecutive cycles, out_last on the 8th byte, then busy=0.
- Same as above but out_ready toggles 1,0,0,1,... -> identical byte sequence, out_byte stable during stalls, no duplicated or skipped bytes.
- Config 3x2; write (2,1) twice, then (3,0), then the remaining cells -> err_dup=1, err_range=1; compile_done pulses only after 6 unique cells, and the second value of (2,1) is the one transmitted.
- cfg_rows=0 or cfg_rows=MAX_ROWS+1 -> err_range=1, cfg_ready stays 1, busy=0; a following valid config is accepted and clears err_range.
- Full MAX_ROWS x MAX_COLS matrix with value = address, then rst asserted mid-TX after 100 bytes -> out_valid=0 next cycle; reconfigure 1x1 -> exactly BYTES bytes with out_last on the final byte.
- With MATRIX_STREAM_HEADER_EN defined, config 2x3 -> first two bytes are 0x02, 0x03, followed by 6*BYTES payload bytes, with out_last only on the final payload byte.
